alu_issue_ctrl: RTL

- Two-requester arbiter and sequencer around one alu_simple instance.
- Accepts packed micro-ops from two requesters over valid/ready and grants them round-robin.
- Drives the ALU from registered operands, captures Out/Flags, and keeps the architectural flag register updated by S-qualified ops.
- Returns results on a single response port tagged with the requester id.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_simple.sv | 63 ++++++
 rtl/rr_arb2.sv | 47 ++++
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller and its ALU.
package alu_pkg;

    localparam int unsigned ALU_W  = 32;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SRB_W  = 5;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned UOP_W  = 77;

    // Micro-op field bit positions within the raw request bus
    localparam int unsigned UOP_S_BIT   = 0;
    localparam int unsigned UOP_SRC_LSB = 1;
    localparam int unsigned UOP_SRC_MSB = 3;
    localparam int unsigned UOP_SRB_LSB = 4;
    localparam int unsigned UOP_SRB_MSB = 8;
    localparam int unsigned UOP_OP_LSB  = 9;
    localparam int unsigned UOP_OP_MSB  = 12;
    localparam int unsigned UOP_IN2_LSB = 13;
    localparam int unsigned UOP_IN2_MSB = 44;
    localparam int unsigned UOP_IN1_LSB = 45;
    localparam int unsigned UOP_IN1_MSB = 76;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;

    localparam logic [SRC_W-1:0] SR_NONE = 3'd0;
    localparam logic [SRC_W-1:0] SR_SHR  = 3'd1;
    localparam logic [SRC_W-1:0] SR_SHL  = 3'd2;
    localparam logic [SRC_W-1:0] SR_ROR  = 3'd3;

    typedef struct packed {
        logic [ALU_W-1:0] in1;
        logic [ALU_W-1:0] in2;
        logic [OP_W-1:0]  opcode;
        logic [SRB_W-1:0] sr_bit;
        logic [SRC_W-1:0] sr_cont;
        logic             s;
    } uop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Split the raw request bus into its named fields
    function automatic uop_t unpack_uop(input logic [UOP_W-1:0] raw);
        uop_t u;
        u.in1     = raw[UOP_IN1_MSB:UOP_IN1_LSB];
        u.in2     = raw[UOP_IN2_MSB:UOP_IN2_LSB];
        u.opcode  = raw[UOP_OP_MSB:UOP_OP_LSB];
        u.sr_bit  = raw[UOP_SRB_MSB:UOP_SRB_LSB];
        u.sr_cont = raw[UOP_SRC_MSB:UOP_SRC_LSB];
        u.s       = raw[UOP_S_BIT];
        return u;
    endfunction

    // An op is legal when both the opcode and the shift control are known
    function automatic logic uop_legal(input uop_t u);
        return (u.opcode <= OP_XOR) && (u.sr_cont <= SR_ROR);
    endfunction

endpackage

// File: rtl/alu_simple.sv
// Combinational 32-bit ALU with pre-shifted second operand.
// Flags = {N, Z, C, V}; C/V are only meaningful for add/sub (C is carry-out,
// i.e. "no borrow" for sub) and are zero for the other opcodes.
module alu_simple
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0]  in1,
    input  logic [ALU_W-1:0]  in2,
    input  logic [OP_W-1:0]   opcode,
    input  logic [SRB_W-1:0]  sr_bit,
    input  logic [SRC_W-1:0]  sr_cont,
    output logic [ALU_W-1:0]  out,
    output logic [FLAG_W-1:0] flags
);

    logic [ALU_W-1:0] b_sh;
    logic [ALU_W:0]   sum;
    logic [ALU_W-1:0] res;
    logic             c_flag;
    logic             v_flag;

    // Shift stage applied to the second operand
    always_comb begin
        b_sh = in2;
        case (sr_cont)
            SR_SHR:  b_sh = in2 >> sr_bit;
            SR_SHL:  b_sh = in2 << sr_bit;
            SR_ROR:  b_sh = ALU_W'({in2, in2} >> sr_bit);
            default: b_sh = in2;
        endcase
    end

    // Arithmetic/logic stage and flag generation
    always_comb begin
        sum    = '0;
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (opcode)
            OP_ADD: begin
                sum    = {1'b0, in1} + {1'b0, b_sh};
                res    = sum[ALU_W-1:0];
                c_flag = sum[ALU_W];
                v_flag = (in1[ALU_W-1] == b_sh[ALU_W-1]) && (res[ALU_W-1] != in1[ALU_W-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, in1} + {1'b0, ~b_sh} + (ALU_W+1)'(1);
                res    = sum[ALU_W-1:0];
                c_flag = sum[ALU_W];
                v_flag = (in1[ALU_W-1] != b_sh[ALU_W-1]) && (res[ALU_W-1] != in1[ALU_W-1]);
            end
            OP_MUL:  res = in1 * b_sh;
            OP_OR:   res = in1 | b_sh;
            OP_AND:  res = in1 & b_sh;
            OP_XOR:  res = in1 ^ b_sh;
            default: res = '0;
        endcase
    end

    assign out   = res;
    assign flags = {res[ALU_W-1], (res == '0), c_flag, v_flag};

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves only when a response completes.
module rr_arb2 #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       done,
    input  logic       done_id,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Grant a lone requester, or the pointer holder on contention
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Hand priority to the other requester once a response is consumed
    always_comb begin
        ptr_d = ptr_q;
        if (done) begin
            ptr_d = ~done_id;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= RR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Arbitrates two micro-op requesters onto one ALU and returns tagged results.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter logic        RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [UOP_W-1:0]  req0_uop,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [UOP_W-1:0]  req1_uop,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_err,
    output logic [FLAG_W-1:0] flags_q,
    output logic              busy
);

    state_t             state_q, state_d;
    uop_t               uop_q, uop_d;
    logic               id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0]  rsp_flags_q, rsp_flags_d;
    logic               rsp_err_q, rsp_err_d;
    logic [FLAG_W-1:0]  flags_d;
    logic               busy_q, busy_d;

    logic [1:0]         gnt;
    logic               rsp_done;
    logic               op_legal;
    uop_t               uop0, uop1;
    logic [ALU_W-1:0]   alu_out;
    logic [FLAG_W-1:0]  alu_flags;

    assign uop0     = unpack_uop(req0_uop);
    assign uop1     = unpack_uop(req1_uop);
    assign rsp_done = rsp_valid_q & rsp_ready;
    assign op_legal = uop_legal(uop_q);

    rr_arb2 #(
        .RR_INIT (RR_INIT)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .en      (state_q == ST_IDLE),
        .done    (rsp_done),
        .done_id (id_q),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // ALU only ever sees the latched operands
    alu_simple u_alu (
        .in1     (uop_q.in1),
        .in2     (uop_q.in2),
        .opcode  (uop_q.opcode),
        .sr_bit  (uop_q.sr_bit),
        .sr_cont (uop_q.sr_cont),
        .out     (alu_out),
        .flags   (alu_flags)
    );

    // Next-state and datapath control: IDLE accept, EXEC capture, RESP hold
    always_comb begin
        state_d     = state_q;
        uop_d       = uop_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        flags_d     = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt[0]) begin
                    uop_d   = uop0;
                    id_d    = 1'b0;
                    state_d = ST_EXEC;
                end else if (gnt[1]) begin
                    uop_d   = uop1;
                    id_d    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_err_d   = ~op_legal;
                rsp_data_d  = op_legal ? alu_out : '0;
                rsp_flags_d = op_legal ? alu_flags : '0;
                if (op_legal && uop_q.s) begin
                    flags_d = alu_flags;
                end
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            uop_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            flags_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            uop_q       <= uop_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
